// File: rtl/pulse_emitter.sv
// Pulse-filter link transmitter: turns queued pulse requests into HIGH_LEN-high / GAP_LEN-low pulses.
// Optional test aid: define PULSE_GLITCH_EN to inject a 1-cycle glitch in the gap (needs GAP_LEN>=3).
module pulse_emitter #(
    parameter int unsigned HIGH_LEN = 3,
    parameter int unsigned GAP_LEN  = 2,
    parameter int unsigned PEND_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [3:0]        req_count,
    output logic              req_ready,
    output logic              line_out,
    output logic              busy,
    output logic              done,
    output logic [PEND_W-1:0] pending
);

    localparam int unsigned MAX_LEN   = (HIGH_LEN > GAP_LEN) ? HIGH_LEN : GAP_LEN;
    localparam int unsigned TMR_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned READY_MAX = (2 ** PEND_W) - 1 - 15;
    localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(HIGH_LEN - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              line_q, line_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              dec;

    // Headroom of one max-size request keeps the counter from wrapping.
    assign req_ready = (pending_q <= PEND_W'(READY_MAX));
    assign accept    = req_valid && req_ready;
    assign dec       = (state_q == HIGH) && (timer_q == HIGH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            line_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, timer and pending count; pending_d is used so a late request extends the burst.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        pending_d = pending_q + (accept ? PEND_W'(req_count) : PEND_W'(0)) - PEND_W'(dec);

        case (state_q)
            IDLE: begin
                if (pending_d != '0) begin
                    state_d = HIGH;
                    timer_d = '0;
                end
            end
            HIGH: begin
                if (timer_q == HIGH_LAST) begin
                    state_d = GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (pending_d != '0) begin
                        state_d = HIGH;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
        line_d = (state_d == HIGH);
`ifdef PULSE_GLITCH_EN
        if ((GAP_LEN >= 3) && (state_d == GAP) && (timer_d == TMR_W'(1))) begin
            line_d = 1'b1;
        end
`endif
    end

    assign line_out = line_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pending  = pending_q;

endmodule
